// File: rtl/dbus_decoder_n.sv
// Data-bus decoder: steers one core data port to NSLV slaves by address field,
// tracking outstanding reads in order so slaves may answer with any latency.
module dbus_decoder_n #(
  parameter int unsigned NSLV        = 2,
  parameter int unsigned DEC_HI      = 31,
  parameter int unsigned DEC_LO      = 28,
  parameter logic [NSLV*(DEC_HI-DEC_LO+1)-1:0] SLV_BASE = {4'h9, 4'h0},
  parameter int unsigned DEFAULT_SLV = 0,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 m_wready,
  output logic                 m_wvalid,
  input  logic [31:0]          m_waddr,
  input  logic [31:0]          m_wdata,
  input  logic [3:0]           m_wstrb,
  input  logic                 m_rready,
  output logic                 m_rvalid,
  input  logic [31:0]          m_raddr,
  output logic                 m_rrsp_valid,
  output logic                 m_rresp,
  output logic [31:0]          m_rdata,
  output logic [NSLV-1:0]      s_wready,
  input  logic [NSLV-1:0]      s_wvalid,
  output logic [31:0]          s_waddr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_wstrb,
  output logic [NSLV-1:0]      s_rready,
  input  logic [NSLV-1:0]      s_rvalid,
  output logic [31:0]          s_raddr,
  input  logic [NSLV-1:0]      s_rrsp_valid,
  input  logic [NSLV-1:0]      s_rresp,
  input  logic [NSLV*32-1:0]   s_rdata,
  output logic                 bus_err
);

  localparam int unsigned DW = DEC_HI - DEC_LO + 1;
  localparam int unsigned IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(OUTSTANDING) + 1;

  // Returns {miss, slave index}; lowest matching index wins.
  function automatic logic [IW:0] decode(input logic [31:0] addr);
    logic           hit;
    logic [IW-1:0]  idx;
    hit = 1'b0;
    idx = (DEFAULT_SLV < NSLV) ? IW'(DEFAULT_SLV) : '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!hit && addr[DEC_HI:DEC_LO] == SLV_BASE[i*DW +: DW]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
    return {(!hit && DEFAULT_SLV >= NSLV), idx};
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [IW:0]    fifo_q [OUTSTANDING];
  logic [IW:0]    fifo_d [OUTSTANDING];
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [IW:0]    w_dec, r_dec, head;
  logic           w_miss, r_miss, full, empty, push, pop;
  logic [IW-1:0]  sel_w, sel_r, head_idx;
  logic [NSLV-1:0] stray;

  assign s_waddr = m_waddr;
  assign s_wdata = m_wdata;
  assign s_wstrb = m_wstrb;
  assign s_raddr = m_raddr;

  always_comb begin
    w_dec    = decode(m_waddr);
    r_dec    = decode(m_raddr);
    w_miss   = w_dec[IW];
    sel_w    = w_dec[IW-1:0];
    r_miss   = r_dec[IW];
    sel_r    = r_dec[IW-1:0];
    full     = (cnt_q == CW'(OUTSTANDING));
    empty    = (cnt_q == '0);
    head     = fifo_q[rptr_q];
    head_idx = head[IW-1:0];

    s_wready = '0;
    if (m_wready && !w_miss) s_wready[sel_w] = 1'b1;
    m_wvalid = w_miss ? 1'b1 : s_wvalid[sel_w];

    // A full FIFO blocks requests even if the head pops this cycle.
    s_rready = '0;
    m_rvalid = 1'b0;
    if (!full) begin
      if (r_miss) begin
        m_rvalid = 1'b1;
      end else begin
        s_rready[sel_r] = m_rready;
        m_rvalid        = s_rvalid[sel_r];
      end
    end
    push = m_rready && m_rvalid;

    m_rrsp_valid = 1'b0;
    m_rresp      = 1'b0;
    m_rdata      = '0;
    stray        = s_rrsp_valid;
    if (!empty) begin
      if (head[IW]) begin
        m_rrsp_valid = 1'b1;
      end else begin
        m_rrsp_valid    = s_rrsp_valid[head_idx];
        m_rresp         = s_rresp[head_idx];
        m_rdata         = s_rdata[head_idx*32 +: 32];
        stray[head_idx] = 1'b0;
      end
    end
    pop = m_rrsp_valid;

    bus_err = resetb && ((m_wready && w_miss) || (m_rready && !full && r_miss) || (|stray));

    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      fifo_d[wptr_q] = {r_miss, sel_r};
      wptr_d         = ptr_inc(wptr_q);
    end
    if (pop) rptr_d = ptr_inc(rptr_q);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      fifo_q <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      fifo_q <= fifo_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dbus_decoder_n.sv
// Directed bench for dbus_decoder_n: one decoder with no default slave plus
// one with slave 0 as default, both driven from the same master/slave stimulus.
module tb_dbus_decoder_n;

  logic        clk = 1'b0;
  logic        resetb;
  logic        m_wready, m_rready;
  logic [31:0] m_waddr, m_wdata, m_raddr;
  logic [3:0]  m_wstrb;
  logic [1:0]  s_wvalid, s_rvalid, s_rrsp_valid, s_rresp;
  logic [63:0] s_rdata;

  logic        m_wvalid, m_rvalid, m_rrsp_valid, m_rresp, bus_err;
  logic [31:0] m_rdata, s_waddr, s_wdata, s_raddr;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_wready, s_rready;

  logic        d_wvalid, d_rvalid, d_rrsp_valid, d_rresp, d_bus_err;
  logic [31:0] d_rdata, d_waddr, d_wdata, d_raddr;
  logic [3:0]  d_wstrb;
  logic [1:0]  d_wready, d_rready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dbus_decoder_n #(.NSLV(2), .DEC_HI(31), .DEC_LO(28), .SLV_BASE({4'h9, 4'h0}),
                   .DEFAULT_SLV(2), .OUTSTANDING(2)) dut (
    .clk(clk), .resetb(resetb),
    .m_wready(m_wready), .m_wvalid(m_wvalid), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rready(m_rready), .m_rvalid(m_rvalid), .m_raddr(m_raddr),
    .m_rrsp_valid(m_rrsp_valid), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .s_wready(s_wready), .s_wvalid(s_wvalid), .s_waddr(s_waddr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rready(s_rready), .s_rvalid(s_rvalid), .s_raddr(s_raddr),
    .s_rrsp_valid(s_rrsp_valid), .s_rresp(s_rresp), .s_rdata(s_rdata), .bus_err(bus_err)
  );

  dbus_decoder_n #(.NSLV(2), .DEC_HI(31), .DEC_LO(28), .SLV_BASE({4'h9, 4'h0}),
                   .DEFAULT_SLV(0), .OUTSTANDING(2)) dut_d (
    .clk(clk), .resetb(resetb),
    .m_wready(m_wready), .m_wvalid(d_wvalid), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rready(m_rready), .m_rvalid(d_rvalid), .m_raddr(m_raddr),
    .m_rrsp_valid(d_rrsp_valid), .m_rresp(d_rresp), .m_rdata(d_rdata),
    .s_wready(d_wready), .s_wvalid(s_wvalid), .s_waddr(d_waddr), .s_wdata(d_wdata),
    .s_wstrb(d_wstrb), .s_rready(d_rready), .s_rvalid(s_rvalid), .s_raddr(d_raddr),
    .s_rrsp_valid(s_rrsp_valid), .s_rresp(s_rresp), .s_rdata(s_rdata), .bus_err(d_bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetb = 1'b0; m_wready = 1'b0; m_rready = 1'b0;
    m_waddr = '0; m_wdata = '0; m_wstrb = '0; m_raddr = '0;
    s_wvalid = '0; s_rvalid = '0; s_rrsp_valid = '0; s_rresp = '0; s_rdata = '0;
    tick(); tick();
    chk("rst_rrsp_valid", 32'(m_rrsp_valid), 32'd0);
    chk("rst_rdata", m_rdata, 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    resetb = 1'b1;
    tick();

    // Write to slave 1, same-cycle accept
    m_wready = 1'b1; m_waddr = 32'h9000_0004; m_wdata = 32'hDEAD_BEEF; m_wstrb = 4'hF;
    s_wvalid = 2'b10;
    #1;
    chk("w1_s_wready", 32'(s_wready), 32'h2);
    chk("w1_m_wvalid", 32'(m_wvalid), 32'd1);
    chk("w1_bus_err", 32'(bus_err), 32'd0);
    chk("w1_s_wdata", s_wdata, 32'hDEAD_BEEF);
    s_wvalid = 2'b01;
    #1;
    chk("w1_stall_m_wvalid", 32'(m_wvalid), 32'd0);
    tick();

    // Write miss: no default on dut, slave 0 default on dut_d
    m_waddr = 32'h3000_0000; s_wvalid = 2'b11;
    #1;
    chk("wm_s_wready", 32'(s_wready), 32'h0);
    chk("wm_m_wvalid", 32'(m_wvalid), 32'd1);
    chk("wm_bus_err", 32'(bus_err), 32'd1);
    chk("wd_s_wready", 32'(d_wready), 32'h1);
    chk("wd_bus_err", 32'(d_bus_err), 32'd0);
    tick();
    m_wready = 1'b0; s_wvalid = '0;

    // Two back-to-back reads, slave 1 answers early
    s_rdata = {32'h5555_0002, 32'hAAAA_0001}; s_rresp = 2'b11; s_rvalid = 2'b11;
    m_rready = 1'b1; m_raddr = 32'h0000_0010;
    #1;
    chk("r1_s_rready", 32'(s_rready), 32'h1);
    chk("r1_m_rvalid", 32'(m_rvalid), 32'd1);
    tick();
    m_raddr = 32'h9000_0000;
    #1;
    chk("r2_s_rready", 32'(s_rready), 32'h2);
    chk("r2_m_rvalid", 32'(m_rvalid), 32'd1);
    chk("r2_no_rsp_same_cycle", 32'(m_rrsp_valid), 32'd0);
    tick();
    m_rready = 1'b0; s_rrsp_valid = 2'b10;
    #1;
    chk("early_rrsp_valid", 32'(m_rrsp_valid), 32'd0);
    chk("early_bus_err", 32'(bus_err), 32'd1);
    tick();
    s_rrsp_valid = 2'b01;
    #1;
    chk("rsp1_valid", 32'(m_rrsp_valid), 32'd1);
    chk("rsp1_data", m_rdata, 32'hAAAA_0001);
    chk("rsp1_resp", 32'(m_rresp), 32'd1);
    chk("rsp1_bus_err", 32'(bus_err), 32'd0);
    tick();
    s_rrsp_valid = 2'b10;
    #1;
    chk("rsp2_valid", 32'(m_rrsp_valid), 32'd1);
    chk("rsp2_data", m_rdata, 32'h5555_0002);
    chk("rsp2_bus_err", 32'(bus_err), 32'd0);
    tick();
    s_rrsp_valid = 2'b01;
    #1;
    chk("empty_rrsp_valid", 32'(m_rrsp_valid), 32'd0);
    chk("empty_rdata", m_rdata, 32'h0);
    chk("empty_bus_err", 32'(bus_err), 32'd1);
    tick();
    s_rrsp_valid = '0;

    // Fill the tracker, third read blocked until a pop
    m_rready = 1'b1; m_raddr = 32'h0000_0020;
    tick(); tick();
    #1;
    chk("full_m_rvalid", 32'(m_rvalid), 32'd0);
    chk("full_s_rready", 32'(s_rready), 32'h0);
    tick();
    s_rrsp_valid = 2'b01; s_rresp = 2'b10;
    #1;
    chk("full_pop_valid", 32'(m_rrsp_valid), 32'd1);
    chk("full_pop_resp", 32'(m_rresp), 32'd0);
    chk("full_nobypass_m_rvalid", 32'(m_rvalid), 32'd0);
    tick();
    s_rrsp_valid = '0;
    #1;
    chk("after_pop_m_rvalid", 32'(m_rvalid), 32'd1);
    chk("after_pop_s_rready", 32'(s_rready), 32'h1);
    tick();
    m_rready = 1'b0; s_rrsp_valid = 2'b01; s_rresp = 2'b11;
    #1;
    chk("drain1_valid", 32'(m_rrsp_valid), 32'd1);
    tick();
    #1;
    chk("drain2_valid", 32'(m_rrsp_valid), 32'd1);
    tick();
    s_rrsp_valid = '0;
    #1;
    chk("drained_valid", 32'(m_rrsp_valid), 32'd0);

    // Read decode miss answered with an error response
    m_rready = 1'b1; m_raddr = 32'h3000_0000;
    #1;
    chk("rm_m_rvalid", 32'(m_rvalid), 32'd1);
    chk("rm_s_rready", 32'(s_rready), 32'h0);
    chk("rm_bus_err", 32'(bus_err), 32'd1);
    chk("rd_s_rready", 32'(d_rready), 32'h1);
    tick();
    m_rready = 1'b0;
    #1;
    chk("rm_rsp_valid", 32'(m_rrsp_valid), 32'd1);
    chk("rm_rsp_resp", 32'(m_rresp), 32'd0);
    chk("rm_rsp_data", m_rdata, 32'h0);
    tick();
    #1;
    chk("rm_rsp_done", 32'(m_rrsp_valid), 32'd0);

    // Reset with two reads outstanding
    m_rready = 1'b1; m_raddr = 32'h9000_0000;
    tick(); tick();
    m_rready = 1'b0; s_rrsp_valid = 2'b10; resetb = 1'b0;
    #1;
    chk("arst_rrsp_valid", 32'(m_rrsp_valid), 32'd0);
    chk("arst_bus_err", 32'(bus_err), 32'd0);
    tick();
    resetb = 1'b1;
    #1;
    chk("post_rst_rrsp_valid", 32'(m_rrsp_valid), 32'd0);
    chk("post_rst_stale_bus_err", 32'(bus_err), 32'd1);
    tick();
    s_rrsp_valid = '0; m_rready = 1'b1;
    #1;
    chk("post_rst_acc1", 32'(m_rvalid), 32'd1);
    tick();
    #1;
    chk("post_rst_acc2", 32'(m_rvalid), 32'd1);
    tick();
    #1;
    chk("post_rst_full", 32'(m_rvalid), 32'd0);
    m_rready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
